avalon_mm_host_bridge: RTL and testbench

Single-outstanding Avalon-MM host (initiator) that turns the RISC-V core's load/store requests into Avalon-MM read/write transfers toward the peripheral slaves, such as the switch PIO, LED PIO and timer. It sits between the core's data-memory port and the Avalon interconnect. It honours `waitrequest` and `readdatavalid`, and a watchdog returns an error response when a slave never answers.

---
 rtl/avalon_mm_pkg.sv | 16 +
 rtl/amm_watchdog.sv | 26 ++
 rtl/avalon_mm_host_bridge.sv | 147 ++++++++++++++
 tb/tb_avalon_mm_host_bridge.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_mm_pkg.sv
// Shared types and constants for the Avalon-MM host bridge.
package avalon_mm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RDWAIT,
        RESP
    } amm_state_t;

    localparam int unsigned AMM_DATA_W = 32;
    localparam int unsigned AMM_BE_W   = 4;

    localparam logic [AMM_DATA_W-1:0] AMM_ERR_RDATA = '0;

endpackage

// File: rtl/amm_watchdog.sv
// Up-counter that flags a transfer whose slave has made no progress for TIMEOUT cycles.
module amm_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign expired = (r_count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/avalon_mm_host_bridge.sv
// Single-outstanding Avalon-MM host: core load/store requests to Avalon read/write transfers,
// with a watchdog that answers with an error when the slave never responds.
module avalon_mm_host_bridge
    import avalon_mm_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [AMM_DATA_W-1:0] req_wdata,
    input  logic [AMM_BE_W-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [AMM_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [AMM_DATA_W-1:0] avm_writedata,
    output logic [AMM_BE_W-1:0]   avm_byteenable,
    input  logic                  avm_waitrequest,
    input  logic [AMM_DATA_W-1:0] avm_readdata,
    input  logic                  avm_readdatavalid
);

    amm_state_t            r_state;
    amm_state_t            w_state_d;
    logic [ADDR_W-1:0]     r_addr;
    logic [AMM_DATA_W-1:0] r_wdata;
    logic [AMM_BE_W-1:0]   r_be;
    logic                  r_we;
    logic [AMM_DATA_W-1:0] r_rdata;
    logic                  r_err;

    logic w_accept;
    logic w_take_data;
    logic w_timeout;
    logic w_wd_en;
    logic w_expired;

    amm_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_accept),
        .enable  (w_wd_en),
        .expired (w_expired)
    );

    always_comb begin
        w_state_d   = r_state;
        req_ready   = 1'b0;
        avm_read    = 1'b0;
        avm_write   = 1'b0;
        rsp_valid   = 1'b0;
        w_accept    = 1'b0;
        w_take_data = 1'b0;
        w_timeout   = 1'b0;
        w_wd_en     = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = !reset;
                if (req_valid && !reset) begin
                    w_accept  = 1'b1;
                    w_state_d = CMD;
                end
            end
            CMD: begin
                w_wd_en = 1'b1;
                if (w_expired) begin
                    w_timeout = 1'b1;
                    w_state_d = RESP;
                end else begin
                    avm_read  = !r_we;
                    avm_write = r_we;
                    // readdatavalid only counts once the command has been accepted
                    if (!avm_waitrequest) begin
                        if (r_we) begin
                            w_state_d = RESP;
                        end else if (avm_readdatavalid) begin
                            w_take_data = 1'b1;
                            w_state_d   = RESP;
                        end else begin
                            w_state_d = RDWAIT;
                        end
                    end
                end
            end
            RDWAIT: begin
                w_wd_en = 1'b1;
                if (w_expired) begin
                    w_timeout = 1'b1;
                    w_state_d = RESP;
                end else if (avm_readdatavalid) begin
                    w_take_data = 1'b1;
                    w_state_d   = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                w_state_d = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_we    <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_addr  <= req_addr & ~ADDR_W'(3);
                r_wdata <= req_wdata;
                r_be    <= req_be;
                r_we    <= req_we;
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
            if (w_take_data) begin
                r_rdata <= avm_readdata;
            end
            if (w_timeout) begin
                r_err   <= 1'b1;
                r_rdata <= AMM_ERR_RDATA;
            end
        end
    end

    assign avm_address    = r_addr;
    assign avm_writedata  = r_wdata;
    assign avm_byteenable = r_be;
    assign rsp_rdata      = (r_state == RESP) ? r_rdata : '0;
    assign rsp_err        = (r_state == RESP) && r_err;

endmodule

// File: tb/tb_avalon_mm_host_bridge.sv
// Directed and randomized bench for avalon_mm_host_bridge against a cycle-count reference model.
module tb_avalon_mm_host_bridge;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avalon_mm_host_bridge #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_we            (req_we),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_be            (req_be),
        .rsp_valid         (rsp_valid),
        .rsp_rdata         (rsp_rdata),
        .rsp_err           (rsp_err),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string ctx);
        chk({ctx, ".req_ready"}, 32'(req_ready), 32'd0);
        chk({ctx, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({ctx, ".rsp_err"}, 32'(rsp_err), 32'd0);
        chk({ctx, ".rsp_rdata"}, rsp_rdata, 32'd0);
        chk({ctx, ".avm_read"}, 32'(avm_read), 32'd0);
        chk({ctx, ".avm_write"}, 32'(avm_write), 32'd0);
        chk({ctx, ".avm_address"}, avm_address, 32'd0);
        chk({ctx, ".avm_writedata"}, avm_writedata, 32'd0);
        chk({ctx, ".avm_byteenable"}, 32'(avm_byteenable), 32'd0);
    endtask

    task automatic scramble_req();
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    // lat < 0 models a slave that never returns read data.
    task automatic do_txn(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int nwait,
                          input int lat, input logic [31:0] rdata);
        int          ev;
        int          resp_k;
        int          cmd_last;
        logic        err;
        logic        cmd;
        logic [31:0] aligned;
        logic [31:0] exp_rdata;
        // Cycles after acceptance until the slave makes its final move.
        ev        = we ? nwait : ((lat < 0) ? 100000 : nwait + lat);
        err       = (ev >= int'(TIMEOUT));
        resp_k    = err ? int'(TIMEOUT) + 2 : ev + 2;
        cmd_last  = (nwait + 1 < int'(TIMEOUT)) ? nwait + 1 : int'(TIMEOUT);
        aligned   = {addr[31:2], 2'b00};
        exp_rdata = (!we && !err) ? rdata : 32'd0;

        #1;
        req_valid         = 1'b1;
        req_we            = we;
        req_addr          = addr;
        req_wdata         = wdata;
        req_be            = be;
        avm_waitrequest   = 1'($urandom);
        avm_readdatavalid = 1'($urandom);
        avm_readdata      = $urandom;
        #1;
        chk({name, ".req_ready_idle"}, 32'(req_ready), 32'd1);
        @(posedge clk);

        for (int k = 1; k <= resp_k + 2; k++) begin
            #1;
            scramble_req();
            avm_waitrequest   = (k <= nwait);
            avm_readdata      = $urandom;
            avm_readdatavalid = 1'b0;
            if (!we && lat >= 0 && k == nwait + 1 + lat) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = rdata;
            end else if (!we && k == 1 && nwait > 0) begin
                avm_readdatavalid = 1'b1;
            end else if (k == resp_k + 1) begin
                avm_readdatavalid = 1'b1;
            end
            #1;
            cmd = (k <= cmd_last);
            chk($sformatf("%s.avm_read@%0d", name, k), 32'(avm_read), 32'(cmd && !we));
            chk($sformatf("%s.avm_write@%0d", name, k), 32'(avm_write), 32'(cmd && we));
            chk($sformatf("%s.avm_address@%0d", name, k), avm_address, aligned);
            chk($sformatf("%s.avm_writedata@%0d", name, k), avm_writedata, wdata);
            chk($sformatf("%s.avm_byteenable@%0d", name, k), 32'(avm_byteenable), 32'(be));
            chk($sformatf("%s.rsp_valid@%0d", name, k), 32'(rsp_valid), 32'(k == resp_k));
            chk($sformatf("%s.req_ready@%0d", name, k), 32'(req_ready), 32'(k > resp_k));
            if (k == resp_k) begin
                chk({name, ".rsp_err"}, 32'(rsp_err), 32'(err));
                chk({name, ".rsp_rdata"}, rsp_rdata, exp_rdata);
            end
            @(posedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        scramble_req();
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'd0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("por");
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("por.req_ready_after_release", 32'(req_ready), 32'd1);
        @(posedge clk);

        do_txn("store", 1'b1, 32'h0000_0008, 32'h0003_FFFF, 4'hF, 0, 0, 32'd0);
        do_txn("load_pio", 1'b0, 32'h0000_0000, 32'd0, 4'hF, 0, 1, 32'h0002_A5A5);
        do_txn("load_wait3", 1'b0, 32'h0000_0010, 32'd0, 4'h3, 3, 1, 32'hCAFE_0001);
        do_txn("store_wait2", 1'b1, 32'h0000_0104, 32'h1234_5678, 4'h6, 2, 0, 32'd0);
        do_txn("load_lat0", 1'b0, 32'h0000_0020, 32'd0, 4'hF, 0, 0, 32'hDEAD_BEEF);
        do_txn("load_timeout", 1'b0, 32'h0000_0040, 32'd0, 4'hF, 0, -1, 32'd0);
        do_txn("load_rdv_at_expiry", 1'b0, 32'h0000_0044, 32'd0, 4'hF, 0, 8, 32'h5555_AAAA);
        do_txn("store_wait_timeout", 1'b1, 32'h0000_0048, 32'hFFFF_0000, 4'hC, 12, 0, 32'd0);
        do_txn("load_just_in_time", 1'b0, 32'h0000_004C, 32'd0, 4'hF, 2, 5, 32'h0BAD_F00D);
        do_txn("unaligned", 1'b1, 32'h0000_0006, 32'hA5A5_5A5A, 4'h1, 0, 0, 32'd0);

        // Reset while the bridge waits for read data.
        #1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0010;
        req_wdata = 32'h1111_2222;
        req_be    = 4'hF;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        @(posedge clk);
        #1;
        scramble_req();
        #1;
        chk("rst_mid.cmd_read", 32'(avm_read), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid.rdwait_read", 32'(avm_read), 32'd0);
        @(posedge clk);
        #2;
        check_reset_vals("rst_mid");
        @(posedge clk);
        #1;
        reset             = 1'b0;
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'h7777_7777;
        #1;
        chk("rst_mid.req_ready", 32'(req_ready), 32'd1);
        chk("rst_mid.no_rsp0", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        avm_readdatavalid = 1'b0;
        #1;
        chk("rst_mid.no_rsp1", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        do_txn("after_reset", 1'b0, 32'h0000_0014, 32'd0, 4'hF, 1, 1, 32'h0042_4242);

        for (int i = 0; i < 30; i++) begin
            logic we;
            int   nwait;
            int   lat;
            we    = 1'($urandom);
            nwait = int'($urandom_range(0, 4));
            lat   = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 6));
            do_txn($sformatf("rand%0d", i), we, $urandom, $urandom, 4'($urandom), nwait, lat,
                   $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
